// File: rtl/fir_serial_prog.sv
// Programmable-coefficient FIR filter: one shared MAC is stepped over NUM_TAPS, and the result is rounded and saturated to WIDTH.
// Latency: an accept in cycle t raises out_valid in cycle t+NUM_TAPS+1. Under backpressure Yn_reg and out_valid are held and in_ready stays low.
module fir_serial_prog #(
   parameter int WIDTH      = 16,
   parameter int NUM_TAPS   = 8,
   parameter int COEF_WIDTH = 16,
   parameter int FRAC_BITS  = 15,
   // wide enough to carry an out-of-range tap index, so such writes can be flagged
   localparam int AW        = $clog2(NUM_TAPS + 1)
) (
   input  logic                  clk,
   input  logic                  arst_n,
   input  logic                  clr,
   input  logic [WIDTH-1:0]      Xn,
   input  logic                  in_valid,
   output logic                  in_ready,
   output logic [WIDTH-1:0]      Yn_reg,
   output logic                  out_valid,
   input  logic                  out_ready,
   input  logic                  coef_we,
   input  logic [AW-1:0]         coef_addr,
   input  logic [COEF_WIDTH-1:0] coef_wdata,
   output logic                  coef_err
);

   localparam int TW   = $clog2(NUM_TAPS);
   localparam int PW   = WIDTH + COEF_WIDTH;
   localparam int ACCW = PW + TW;
   localparam int EXTW = ACCW + 1 - WIDTH;

   localparam logic signed [ACCW:0] RND_K = $signed({{ACCW{1'b0}}, 1'b1} << (FRAC_BITS - 1));
   localparam logic signed [ACCW:0] Y_MAX = $signed({{EXTW{1'b0}}, 1'b0, {(WIDTH-1){1'b1}}});
   localparam logic signed [ACCW:0] Y_MIN = $signed({{EXTW{1'b1}}, 1'b1, {(WIDTH-1){1'b0}}});

   typedef enum logic [1:0] {IDLE, MAC, OUT} state_t;

   state_t                        state;
   logic                          in_rdy_q;
   logic [TW-1:0]                 tap;
   logic signed [ACCW-1:0]        acc;
   logic signed [WIDTH-1:0]       delay [NUM_TAPS];
   logic signed [COEF_WIDTH-1:0]  coef  [NUM_TAPS];

   logic signed [PW-1:0]          d_ext;
   logic signed [PW-1:0]          c_ext;
   logic signed [PW-1:0]          prod;
   logic signed [ACCW-1:0]        acc_next;
   logic signed [ACCW:0]          rnd_sum;
   logic signed [ACCW:0]          shifted;
   logic [WIDTH-1:0]              sat_y;
   logic                          is_last;
   logic                          coef_ok;

   assign in_ready = in_rdy_q & ~clr;
   assign is_last  = (tap == TW'(NUM_TAPS - 1));
   assign coef_ok  = (state == IDLE) && (coef_addr < AW'(NUM_TAPS));

   always_comb begin
      d_ext    = {{COEF_WIDTH{delay[tap][WIDTH-1]}}, delay[tap]};
      c_ext    = {{WIDTH{coef[tap][COEF_WIDTH-1]}}, coef[tap]};
      prod     = d_ext * c_ext;
      acc_next = acc + {{TW{prod[PW-1]}}, prod};
      rnd_sum  = {acc_next[ACCW-1], acc_next} + RND_K;
      shifted  = rnd_sum >>> FRAC_BITS;
      if (shifted > Y_MAX)
         sat_y = {1'b0, {(WIDTH-1){1'b1}}};
      else if (shifted < Y_MIN)
         sat_y = {1'b1, {(WIDTH-1){1'b0}}};
      else
         sat_y = shifted[WIDTH-1:0];
   end

   always_ff @(posedge clk or negedge arst_n) begin
      if (!arst_n) begin
         state     <= IDLE;
         in_rdy_q  <= 1'b1;
         tap       <= '0;
         acc       <= '0;
         Yn_reg    <= '0;
         out_valid <= 1'b0;
         coef_err  <= 1'b0;
         for (int k = 0; k < NUM_TAPS; k++) begin
            delay[k] <= '0;
            coef[k]  <= '0;
         end
      end else begin
         coef_err <= coef_we & ~coef_ok;
         if (coef_we && coef_ok)
            coef[coef_addr[TW-1:0]] <= coef_wdata;

         if (clr) begin
            state     <= IDLE;
            in_rdy_q  <= 1'b1;
            tap       <= '0;
            acc       <= '0;
            out_valid <= 1'b0;
            for (int k = 0; k < NUM_TAPS; k++)
               delay[k] <= '0;
         end else begin
            case (state)
               IDLE: begin
                  if (in_valid) begin
                     for (int k = NUM_TAPS - 1; k > 0; k--)
                        delay[k] <= delay[k-1];
                     delay[0] <= Xn;
                     acc      <= '0;
                     tap      <= '0;
                     in_rdy_q <= 1'b0;
                     state    <= MAC;
                  end
               end
               MAC: begin
                  acc <= acc_next;
                  tap <= tap + TW'(1);
                  if (is_last) begin
                     Yn_reg    <= sat_y;
                     out_valid <= 1'b1;
                     tap       <= '0;
                     state     <= OUT;
                  end
               end
               OUT: begin
                  if (out_ready) begin
                     out_valid <= 1'b0;
                     in_rdy_q  <= 1'b1;
                     state     <= IDLE;
                  end
               end
               default: begin
                  state    <= IDLE;
                  in_rdy_q <= 1'b1;
               end
            endcase
         end
      end
   end

endmodule
